// File: rtl/matmul_tile_engine.sv
// Streaming tiled matrix-multiply engine: C = A x B, 64-bit integer operands.
// Ping-pong step buffers feed a row-parallel MAC array; finished tiles drain row-major.
module matmul_tile_engine #(
    parameter int DATA_WIDTH   = 64,
    parameter int PE_NUM_WIDTH = 2,
    parameter int A_NUM_WIDTH  = 3,
    parameter int B_NUM_WIDTH  = 3,
    parameter int N_MAX_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  A_in,
    input  logic                   A_valid_in,
    input  logic [DATA_WIDTH-1:0]  B_in,
    input  logic                   B_valid_in,
    input  logic [N_MAX_WIDTH-1:0] N_in,
    output logic [DATA_WIDTH-1:0]  C_out,
    output logic                   C_valid_out,
    output logic                   C_last_out
);

    localparam int SI  = 1 << A_NUM_WIDTH;
    localparam int SJ  = 1 << B_NUM_WIDTH;
    localparam int PE  = 1 << PE_NUM_WIDTH;
    localparam int RPP = SI / PE;
    localparam int OW  = A_NUM_WIDTH + B_NUM_WIDTH;

    localparam logic [A_NUM_WIDTH-1:0] LANE_LAST = A_NUM_WIDTH'(SI - 1);
    localparam logic [B_NUM_WIDTH-1:0] COL_LAST  = B_NUM_WIDTH'(SJ - 1);
    localparam logic [OW-1:0]          IDX_LAST  = OW'(SI * SJ - 1);

    // input sequencing
    logic                   busy_q, busy_d;
    logic [N_MAX_WIDTH-1:0] n_q, n_d;
    logic [N_MAX_WIDTH-1:0] step_q, step_d;
    logic [N_MAX_WIDTH-1:0] ti_q, ti_d;
    logic [N_MAX_WIDTH-1:0] tj_q, tj_d;
    logic [A_NUM_WIDTH-1:0] lane_q, lane_d;
    logic                   fill_sel_q, fill_sel_d;
    logic [DATA_WIDTH-1:0]  a_buf_q [2][SI];
    logic [DATA_WIDTH-1:0]  a_buf_d [2][SI];
    logic [DATA_WIDTH-1:0]  b_buf_q [2][SJ];
    logic [DATA_WIDTH-1:0]  b_buf_d [2][SJ];

    // compute sequencing
    logic                   comp_vld_q, comp_vld_d;
    logic                   comp_sel_q, comp_sel_d;
    logic [B_NUM_WIDTH-1:0] comp_c_q, comp_c_d;
    logic                   comp_first_q, comp_first_d;
    logic                   comp_lastn_q, comp_lastn_d;
    logic                   comp_lastj_q, comp_lastj_d;

    // multiply stage
    logic [DATA_WIDTH-1:0]  mul_q [SI];
    logic [DATA_WIDTH-1:0]  mul_d [SI];
    logic                   mul_vld_q, mul_vld_d;
    logic [B_NUM_WIDTH-1:0] mul_col_q, mul_col_d;
    logic                   mul_first_q, mul_first_d;
    logic                   mul_lastn_q, mul_lastn_d;
    logic                   mul_lastj_q, mul_lastj_d;

    // accumulate stage
    logic [DATA_WIDTH-1:0]  acc_q [SI][SJ];
    logic [DATA_WIDTH-1:0]  acc_d [SI][SJ];
    logic                   snap_q, snap_d;
    logic                   snap_last_q, snap_last_d;

    // output bank
    logic [DATA_WIDTH-1:0]  bank_q [SI*SJ];
    logic [DATA_WIDTH-1:0]  bank_d [SI*SJ];
    logic                   out_busy_q, out_busy_d;
    logic [OW-1:0]          out_idx_q, out_idx_d;
    logic                   out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]  c_out_q, c_out_d;
    logic                   c_valid_q, c_valid_d;
    logic                   c_last_q, c_last_d;

    logic                   beat;
    logic                   start;
    logic [N_MAX_WIDTH-1:0] n_eff;
    logic [N_MAX_WIDTH-1:0] nt_last;
    logic                   lane_end;
    logic                   step_end;
    logic                   tj_end;
    logic                   ti_end;

    assign beat     = A_valid_in && B_valid_in;
    assign n_eff    = busy_q ? n_q : N_in;
    assign nt_last  = (n_eff >> A_NUM_WIDTH) - N_MAX_WIDTH'(1);
    assign lane_end = lane_q == LANE_LAST;
    assign step_end = step_q == n_eff - N_MAX_WIDTH'(1);
    assign tj_end   = tj_q == nt_last;
    assign ti_end   = ti_q == nt_last;

    always_comb begin
        busy_d     = busy_q;
        n_d        = n_q;
        step_d     = step_q;
        ti_d       = ti_q;
        tj_d       = tj_q;
        lane_d     = lane_q;
        fill_sel_d = fill_sel_q;
        a_buf_d    = a_buf_q;
        b_buf_d    = b_buf_q;
        start      = 1'b0;
        if (beat) begin
            busy_d = 1'b1;
            n_d    = n_eff;
            a_buf_d[fill_sel_q][lane_q] = A_in;
            b_buf_d[fill_sel_q][lane_q] = B_in;
            lane_d = lane_q + A_NUM_WIDTH'(1);
            if (lane_end) begin
                start      = 1'b1;
                fill_sel_d = ~fill_sel_q;
                if (step_end) begin
                    step_d = '0;
                    if (tj_end) begin
                        tj_d = '0;
                        if (ti_end) begin
                            ti_d   = '0;
                            busy_d = 1'b0;
                        end else begin
                            ti_d = ti_q + N_MAX_WIDTH'(1);
                        end
                    end else begin
                        tj_d = tj_q + N_MAX_WIDTH'(1);
                    end
                end else begin
                    step_d = step_q + N_MAX_WIDTH'(1);
                end
            end
        end
    end

    // A new step can start in the same cycle the previous one finishes column SJ-1
    always_comb begin
        comp_vld_d   = comp_vld_q;
        comp_sel_d   = comp_sel_q;
        comp_c_d     = comp_c_q;
        comp_first_d = comp_first_q;
        comp_lastn_d = comp_lastn_q;
        comp_lastj_d = comp_lastj_q;
        if (comp_vld_q) begin
            comp_c_d = comp_c_q + B_NUM_WIDTH'(1);
            if (comp_c_q == COL_LAST) begin
                comp_vld_d = 1'b0;
            end
        end
        if (start) begin
            comp_vld_d   = 1'b1;
            comp_c_d     = '0;
            comp_sel_d   = fill_sel_q;
            comp_first_d = step_q == '0;
            comp_lastn_d = step_end;
            comp_lastj_d = step_end && tj_end && ti_end;
        end
    end

    always_comb begin
        mul_vld_d   = comp_vld_q;
        mul_col_d   = comp_c_q;
        mul_first_d = comp_first_q;
        mul_lastn_d = comp_lastn_q;
        mul_lastj_d = comp_lastj_q;
        for (int p = 0; p < PE; p++) begin
            for (int k = 0; k < RPP; k++) begin
                mul_d[p*RPP+k] = a_buf_q[comp_sel_q][p*RPP+k]
                               * b_buf_q[comp_sel_q][comp_c_q];
            end
        end
    end

    // Accumulate writes override the snapshot clear on the shared cycle
    always_comb begin
        acc_d       = acc_q;
        snap_d      = 1'b0;
        snap_last_d = snap_last_q;
        if (snap_q) begin
            for (int r = 0; r < SI; r++) begin
                for (int c = 0; c < SJ; c++) begin
                    acc_d[r][c] = '0;
                end
            end
        end
        if (mul_vld_q) begin
            for (int p = 0; p < PE; p++) begin
                for (int k = 0; k < RPP; k++) begin
                    acc_d[p*RPP+k][mul_col_q] = mul_first_q
                        ? mul_q[p*RPP+k]
                        : acc_q[p*RPP+k][mul_col_q] + mul_q[p*RPP+k];
                end
            end
            if (mul_lastn_q && mul_col_q == COL_LAST) begin
                snap_d      = 1'b1;
                snap_last_d = mul_lastj_q;
            end
        end
    end

    always_comb begin
        bank_d     = bank_q;
        out_busy_d = out_busy_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
        c_out_d    = '0;
        c_valid_d  = 1'b0;
        c_last_d   = 1'b0;
        if (out_busy_q) begin
            c_out_d   = bank_q[out_idx_q];
            c_valid_d = 1'b1;
            c_last_d  = out_last_q && (out_idx_q == IDX_LAST);
            out_idx_d = out_idx_q + OW'(1);
            if (out_idx_q == IDX_LAST) begin
                out_busy_d = 1'b0;
            end
        end
        if (snap_q) begin
            for (int r = 0; r < SI; r++) begin
                for (int c = 0; c < SJ; c++) begin
                    bank_d[r*SJ+c] = acc_q[r][c];
                end
            end
            out_busy_d = 1'b1;
            out_idx_d  = '0;
            out_last_d = snap_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q       <= 1'b0;
            n_q          <= '0;
            step_q       <= '0;
            ti_q         <= '0;
            tj_q         <= '0;
            lane_q       <= '0;
            fill_sel_q   <= 1'b0;
            comp_vld_q   <= 1'b0;
            comp_sel_q   <= 1'b0;
            comp_c_q     <= '0;
            comp_first_q <= 1'b0;
            comp_lastn_q <= 1'b0;
            comp_lastj_q <= 1'b0;
            mul_vld_q    <= 1'b0;
            mul_col_q    <= '0;
            mul_first_q  <= 1'b0;
            mul_lastn_q  <= 1'b0;
            mul_lastj_q  <= 1'b0;
            snap_q       <= 1'b0;
            snap_last_q  <= 1'b0;
            out_busy_q   <= 1'b0;
            out_idx_q    <= '0;
            out_last_q   <= 1'b0;
            c_out_q      <= '0;
            c_valid_q    <= 1'b0;
            c_last_q     <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < SI; r++) a_buf_q[b][r] <= '0;
                for (int c = 0; c < SJ; c++) b_buf_q[b][c] <= '0;
            end
            for (int r = 0; r < SI; r++) begin
                mul_q[r] <= '0;
                for (int c = 0; c < SJ; c++) acc_q[r][c] <= '0;
            end
            for (int i = 0; i < SI*SJ; i++) bank_q[i] <= '0;
        end else begin
            busy_q       <= busy_d;
            n_q          <= n_d;
            step_q       <= step_d;
            ti_q         <= ti_d;
            tj_q         <= tj_d;
            lane_q       <= lane_d;
            fill_sel_q   <= fill_sel_d;
            a_buf_q      <= a_buf_d;
            b_buf_q      <= b_buf_d;
            comp_vld_q   <= comp_vld_d;
            comp_sel_q   <= comp_sel_d;
            comp_c_q     <= comp_c_d;
            comp_first_q <= comp_first_d;
            comp_lastn_q <= comp_lastn_d;
            comp_lastj_q <= comp_lastj_d;
            mul_q        <= mul_d;
            mul_vld_q    <= mul_vld_d;
            mul_col_q    <= mul_col_d;
            mul_first_q  <= mul_first_d;
            mul_lastn_q  <= mul_lastn_d;
            mul_lastj_q  <= mul_lastj_d;
            acc_q        <= acc_d;
            snap_q       <= snap_d;
            snap_last_q  <= snap_last_d;
            bank_q       <= bank_d;
            out_busy_q   <= out_busy_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
            c_out_q      <= c_out_d;
            c_valid_q    <= c_valid_d;
            c_last_q     <= c_last_d;
        end
    end

    assign C_out       = c_out_q;
    assign C_valid_out = c_valid_q;
    assign C_last_out  = c_last_q;

endmodule

// File: tb/tb_matmul_tile_engine.sv
// Bench for matmul_tile_engine: reference matrix product queued in tile order,
// compared against every valid output, plus literal checks of known results.
module tb_matmul_tile_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] A_in = '0;
    logic        A_valid_in = 1'b0;
    logic [63:0] B_in = '0;
    logic        B_valid_in = 1'b0;
    logic [31:0] N_in = 32'd16;
    logic [63:0] C_out;
    logic        C_valid_out;
    logic        C_last_out;

    matmul_tile_engine dut (
        .clk        (clk),
        .rst        (rst),
        .A_in       (A_in),
        .A_valid_in (A_valid_in),
        .B_in       (B_in),
        .B_valid_in (B_valid_in),
        .N_in       (N_in),
        .C_out      (C_out),
        .C_valid_out(C_valid_out),
        .C_last_out (C_last_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        last;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    longint      last_beat_cyc = 0;
    longint      first_valid_cyc = -1;
    int          lasts_seen = 0;
    exp_t        exp_q[$];
    exp_t        exp_e;
    logic [63:0] got[$];
    logic [63:0] ma[16][16];
    logic [63:0] mb[16][16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (C_valid_out) begin
            got.push_back(C_out);
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (C_last_out) lasts_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h last %b, required no output",
                         C_out, C_last_out);
            end else begin
                exp_e = exp_q.pop_front();
                if (C_out !== exp_e.d || C_last_out !== exp_e.last) begin
                    errors++;
                    $display("FAIL stream_elem: got %h last %b, required %h last %b",
                             C_out, C_last_out, exp_e.d, exp_e.last);
                end
            end
        end else if (C_last_out) begin
            checks++;
            errors++;
            $display("FAIL last_without_valid: C_last_out=1 with C_valid_out=0");
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic build_expected(int n);
        logic [63:0] s;
        for (int ti = 0; ti < n / 8; ti++)
            for (int tj = 0; tj < n / 8; tj++)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        s = '0;
                        for (int k = 0; k < n; k++)
                            s = s + ma[ti*8+r][k] * mb[k][tj*8+c];
                        exp_q.push_back('{s, (ti*8+r == n-1) && (tj*8+c == n-1)});
                    end
    endtask

    task automatic drive_beat(logic [63:0] a, logic [63:0] b, bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                case ($urandom_range(0, 2))
                    0: begin A_valid_in = 1'b0; B_valid_in = 1'b0; end
                    1: begin
                        A_valid_in = 1'b1; B_valid_in = 1'b0;
                        A_in = {$urandom, $urandom};
                    end
                    default: begin
                        A_valid_in = 1'b0; B_valid_in = 1'b1;
                        B_in = {$urandom, $urandom};
                    end
                endcase
                @(posedge clk); #1;
            end
        end
        A_in = a;
        B_in = b;
        A_valid_in = 1'b1;
        B_valid_in = 1'b1;
        @(posedge clk); #1;
        A_valid_in = 1'b0;
        B_valid_in = 1'b0;
        last_beat_cyc = cyc;
    endtask

    task automatic run_job(int n, bit gaps, int stop_after);
        int cnt = 0;
        N_in = n;
        for (int ti = 0; ti < n / 8; ti++)
            for (int tj = 0; tj < n / 8; tj++)
                for (int s = 0; s < n; s++)
                    for (int k = 0; k < 8; k++) begin
                        if (stop_after >= 0 && cnt == stop_after) return;
                        drive_beat(ma[ti*8+k][s], mb[s][tj*8+k], gaps);
                        if (gaps && cnt == 0) N_in = 32'd8;
                        cnt++;
                    end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_remaining", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic new_job();
        got.delete();
        lasts_seen = 0;
        first_valid_cyc = -1;
    endtask

    task automatic fill_const(logic [63:0] av, logic [63:0] bv);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                ma[r][c] = av;
                mb[r][c] = bv;
            end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_c_out", C_out, 0);
        check("reset_c_valid", C_valid_out, 0);
        check("reset_c_last", C_last_out, 0);
        rst = 1'b1;

        // ones times twos
        fill_const(64'd1, 64'd2);
        new_job();
        build_expected(16);
        run_job(16, 1'b0, -1);
        wait_drain();
        check("t1_count", got.size(), 256);
        check("t1_first", got[0], 64'd32);
        check("t1_lastval", got[255], 64'd32);
        check("t1_last_flags", lasts_seen, 1);

        // identity times index matrix
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                ma[r][c] = (r == c) ? 64'd1 : 64'd0;
                mb[r][c] = 64'(r * 16 + c);
            end
        new_job();
        build_expected(16);
        run_job(16, 1'b0, -1);
        wait_drain();
        check("t2_out0", got[0], 64'd0);
        check("t2_out1", got[1], 64'd1);
        check("t2_out8", got[8], 64'd16);
        check("t2_out64", got[64], 64'd8);

        // random 64-bit operands, back to back
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                ma[r][c] = {$urandom, $urandom};
                mb[r][c] = {$urandom, $urandom};
            end
        new_job();
        build_expected(16);
        run_job(16, 1'b0, -1);
        wait_drain();
        check("t3_count", got.size(), 256);

        // same operands with gaps and single-sided valids
        new_job();
        build_expected(16);
        run_job(16, 1'b1, -1);
        wait_drain();
        check("t4_count", got.size(), 256);
        check("t4_last_flags", lasts_seen, 1);

        // abort mid-job, then rerun
        fill_const(64'd1, 64'd2);
        new_job();
        build_expected(16);
        run_job(16, 1'b0, 200);
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        check("t5_reset_valid", C_valid_out, 0);
        check("t5_reset_c_out", C_out, 0);
        rst = 1'b1;
        new_job();
        repeat (30) @(posedge clk);
        #1;
        check("t5_no_out_after_reset", got.size(), 0);
        build_expected(16);
        run_job(16, 1'b0, -1);
        wait_drain();
        check("t5_count", got.size(), 256);
        check("t5_mid", got[100], 64'd32);
        check("t5_last_flags", lasts_seen, 1);

        // single tile, latency
        fill_const(64'd3, 64'd5);
        new_job();
        build_expected(8);
        run_job(8, 1'b0, -1);
        wait_drain();
        check("t6_count", got.size(), 64);
        check("t6_first", got[0], 64'd120);
        check("t6_latency", first_valid_cyc - last_beat_cyc, 64'd11);
        check("t6_last_flags", lasts_seen, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
